// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
//
// Final stage of the 3-bit-opcode CPU. Owns architectural registers A, B, C,
// selects operands, performs SHIFT / XOR / MOD / JUMP, writes results back,
// emits 3-bit output values and resolves JNZ, squashing the wrong-path
// instructions already fetched/decoded behind a taken jump.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   halt                global stall; freezes everything except the load port
//   load_en/sel/data    register initialisation port (0=A, 1=B, 2=C, 3=none)
//   operand_id_reg      3-bit operand of the instruction in EX
//   instr_ptr_id_reg    instruction pointer of the instruction in EX
//   op1_sel             0=A, 1=B, 2=C, 3=COMBO
//   op2_sel             2=C, otherwise zero-extended literal
//   operation_sel       0=SHIFT, 1=XOR, 2=MOD, 3=JUMP
//   reg_wr_en           one-hot write enables: A, B, C, OUT (bit4 unused)
//   reg_a/reg_b/reg_c   architectural registers
//   out_valid/out_data  one-cycle output strobe and its 3-bit value
//   jump_taken          combinational redirect request to fetch
//   jump_target         {1'b0, operand}
//   squash_active       the instruction now in EX is being discarded
//   combo_err           sticky: combo operand 7 was used
//   ex_instr_ptr        pointer of the last instruction that executed
// ---------------------------------------------------------------------------
module execute_stage #(
  parameter int REG_WIDTH     = 48,
  parameter int SQUASH_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 halt,
  input  logic                 load_en,
  input  logic [1:0]           load_sel,
  input  logic [REG_WIDTH-1:0] load_data,
  input  logic [2:0]           operand_id_reg,
  input  logic [3:0]           instr_ptr_id_reg,
  input  logic [1:0]           op1_sel,
  input  logic [1:0]           op2_sel,
  input  logic [1:0]           operation_sel,
  input  logic [4:0]           reg_wr_en,
  output logic [REG_WIDTH-1:0] reg_a,
  output logic [REG_WIDTH-1:0] reg_b,
  output logic [REG_WIDTH-1:0] reg_c,
  output logic                 out_valid,
  output logic [2:0]           out_data,
  output logic                 jump_taken,
  output logic [3:0]           jump_target,
  output logic                 squash_active,
  output logic                 combo_err,
  output logic [3:0]           ex_instr_ptr
);

  localparam int CNT_W = $clog2(SQUASH_CYCLES + 1);
  localparam logic [REG_WIDTH-1:0] SHIFT_LIMIT = REG_WIDTH'(REG_WIDTH);
  localparam logic [CNT_W-1:0]     SQUASH_LOAD = CNT_W'(SQUASH_CYCLES);

  typedef enum logic [1:0] {
    OP_SHIFT = 2'd0,
    OP_XOR   = 2'd1,
    OP_MOD   = 2'd2,
    OP_JUMP  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    SRC_A     = 2'd0,
    SRC_B     = 2'd1,
    SRC_C     = 2'd2,
    SRC_COMBO = 2'd3
  } src_e;

  logic [REG_WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic                 out_valid_q, out_valid_d;
  logic [2:0]           out_data_q, out_data_d;
  logic                 combo_err_q, combo_err_d;
  logic [3:0]           ex_ptr_q, ex_ptr_d;
  logic [CNT_W-1:0]     sq_cnt_q, sq_cnt_d;

  op_e                  op;
  logic [REG_WIDTH-1:0] combo, op1, op2, result;
  logic                 combo_is_7, combo_used;
  logic                 exec, squashing, jump_hit;
  logic [3:0]           wr;

  // Bit 4 of the write enable is reserved and has no effect.
  logic unused_wr_bit;
  assign unused_wr_bit = reg_wr_en[4];

  assign op = op_e'(operation_sel);

  // Combo operand decode: 0-3 literal, 4-6 registers, 7 reads as zero.
  // NOTE: every combinational output gets a default first so no path
  // through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    combo      = '0;
    combo_is_7 = 1'b0;
    case (operand_id_reg)
      3'd4:    combo = a_q;
      3'd5:    combo = b_q;
      3'd6:    combo = c_q;
      3'd7:    combo_is_7 = 1'b1;
      default: combo = REG_WIDTH'(operand_id_reg);
    endcase
  end

  always_comb begin
    op1 = a_q;
    case (src_e'(op1_sel))
      SRC_A:     op1 = a_q;
      SRC_B:     op1 = b_q;
      SRC_C:     op1 = c_q;
      SRC_COMBO: op1 = combo;
      default:   op1 = a_q;
    endcase
    op2 = (op2_sel == 2'd2) ? c_q : REG_WIDTH'(operand_id_reg);
  end

  // Combo only matters to SHIFT, or to XOR/MOD when op1 is the combo operand.
  assign combo_used = (op == OP_SHIFT) || ((op != OP_JUMP) && (op1_sel == 2'd3));

  always_comb begin
    result = '0;
    case (op)
      // The shift amount is compared over its full width, so a large
      // register-sourced amount can never alias to a small shift.
      OP_SHIFT: result = (combo >= SHIFT_LIMIT) ? '0 : (a_q >> combo);
      OP_XOR:   result = op1 ^ op2;
      OP_MOD:   result = REG_WIDTH'(op1[2:0]);
      default:  result = '0;
    endcase
  end

  assign exec      = !halt && (sq_cnt_q == '0);
  assign squashing = !halt && (sq_cnt_q != '0);
  assign jump_hit  = exec && (op == OP_JUMP) && (a_q != '0);
  // JUMP never writes, whether taken or not.
  assign wr        = (exec && (op != OP_JUMP)) ? reg_wr_en[3:0] : 4'b0000;

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    out_data_d  = out_data_q;
    out_valid_d = wr[3];
    if (wr[0]) a_d = result;
    if (wr[1]) b_d = result;
    if (wr[2]) c_d = result;
    if (wr[3]) out_data_d = result[2:0];
    // The load port has priority over an execute write to the same register.
    if (load_en) begin
      case (load_sel)
        2'd0:    a_d = load_data;
        2'd1:    b_d = load_data;
        2'd2:    c_d = load_data;
        default: ;
      endcase
    end

    ex_ptr_d    = exec ? instr_ptr_id_reg : ex_ptr_q;
    combo_err_d = combo_err_q | (exec && combo_is_7 && combo_used);

    sq_cnt_d = sq_cnt_q;
    if (jump_hit)       sq_cnt_d = SQUASH_LOAD;
    else if (squashing) sq_cnt_d = sq_cnt_q - CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      combo_err_q <= 1'b0;
      ex_ptr_q    <= '0;
      sq_cnt_q    <= '0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      combo_err_q <= combo_err_d;
      ex_ptr_q    <= ex_ptr_d;
      sq_cnt_q    <= sq_cnt_d;
    end
  end

  assign reg_a         = a_q;
  assign reg_b         = b_q;
  assign reg_c         = c_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign jump_taken    = jump_hit;
  assign jump_target   = {1'b0, operand_id_reg};
  assign squash_active = squashing;
  assign combo_err     = combo_err_q;
  assign ex_instr_ptr  = ex_ptr_q;

endmodule

// File: tb/tb_execute_stage.sv
// ---------------------------------------------------------------------------
// tb_execute_stage
//
// Directed walk through the execute-stage behaviours followed by a randomized
// phase, all checked against a behavioural model of the architectural state
// (registers, output latch, squash budget, sticky error flag).
// ---------------------------------------------------------------------------
module tb_execute_stage;

  localparam int W  = 48;
  localparam int SQ = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          halt;
  logic          load_en;
  logic [1:0]    load_sel;
  logic [W-1:0]  load_data;
  logic [2:0]    operand_id_reg;
  logic [3:0]    instr_ptr_id_reg;
  logic [1:0]    op1_sel, op2_sel, operation_sel;
  logic [4:0]    reg_wr_en;
  logic [W-1:0]  reg_a, reg_b, reg_c;
  logic          out_valid;
  logic [2:0]    out_data;
  logic          jump_taken;
  logic [3:0]    jump_target;
  logic          squash_active;
  logic          combo_err;
  logic [3:0]    ex_instr_ptr;

  execute_stage #(.REG_WIDTH(W), .SQUASH_CYCLES(SQ)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .halt             (halt),
    .load_en          (load_en),
    .load_sel         (load_sel),
    .load_data        (load_data),
    .operand_id_reg   (operand_id_reg),
    .instr_ptr_id_reg (instr_ptr_id_reg),
    .op1_sel          (op1_sel),
    .op2_sel          (op2_sel),
    .operation_sel    (operation_sel),
    .reg_wr_en        (reg_wr_en),
    .reg_a            (reg_a),
    .reg_b            (reg_b),
    .reg_c            (reg_c),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .jump_taken       (jump_taken),
    .jump_target      (jump_target),
    .squash_active    (squash_active),
    .combo_err        (combo_err),
    .ex_instr_ptr     (ex_instr_ptr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [W-1:0] m_a, m_b, m_c;
  logic [2:0]   m_out_data;
  logic         m_out_valid, m_err;
  logic [3:0]   m_ptr;
  int           m_sq;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_a = '0; m_b = '0; m_c = '0;
    m_out_data = '0; m_out_valid = 1'b0; m_err = 1'b0;
    m_ptr = '0; m_sq = 0;
  endtask

  function automatic logic [W-1:0] model_combo();
    case (operand_id_reg)
      3'd4:    return m_a;
      3'd5:    return m_b;
      3'd6:    return m_c;
      3'd7:    return '0;
      default: return W'(operand_id_reg);
    endcase
  endfunction

  function automatic logic [W-1:0] model_src(input logic [1:0] sel);
    case (sel)
      2'd0:    return m_a;
      2'd1:    return m_b;
      2'd2:    return m_c;
      default: return model_combo();
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_clock();
    logic [W-1:0] combo, op1, op2, res;
    logic [63:0]  wide;
    bit           exec, used;
    exec = !halt && (m_sq == 0);
    m_out_valid = 1'b0;
    if (exec) begin
      combo = model_combo();
      op1   = model_src(op1_sel);
      op2   = (op2_sel == 2'd2) ? m_c : W'(operand_id_reg);
      used  = (operation_sel == 2'd0) || (operation_sel != 2'd3 && op1_sel == 2'd3);
      res   = '0;
      case (operation_sel)
        2'd0: begin
          if (combo >= W) res = '0;
          else begin
            wide = 64'(m_a) / (64'd1 << combo);
            res  = wide[W-1:0];
          end
        end
        2'd1:    res = op1 ^ op2;
        2'd2:    res = W'(op1 % 8);
        default: res = '0;
      endcase
      if (operation_sel == 2'd3) begin
        if (m_a != 0) m_sq = SQ;
      end else begin
        if (reg_wr_en[0]) m_a = res;
        if (reg_wr_en[1]) m_b = res;
        if (reg_wr_en[2]) m_c = res;
        if (reg_wr_en[3]) begin
          m_out_valid = 1'b1;
          m_out_data  = res[2:0];
        end
      end
      m_ptr = instr_ptr_id_reg;
      if (used && operand_id_reg == 3'd7) m_err = 1'b1;
    end else if (!halt) begin
      m_sq = m_sq - 1;
    end
    if (load_en) begin
      case (load_sel)
        2'd0: m_a = load_data;
        2'd1: m_b = load_data;
        2'd2: m_c = load_data;
        default: ;
      endcase
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".a"},     64'(reg_a),        64'(m_a));
    check({tag, ".b"},     64'(reg_b),        64'(m_b));
    check({tag, ".c"},     64'(reg_c),        64'(m_c));
    check({tag, ".ov"},    64'(out_valid),    64'(m_out_valid));
    check({tag, ".od"},    64'(out_data),     64'(m_out_data));
    check({tag, ".err"},   64'(combo_err),    64'(m_err));
    check({tag, ".ptr"},   64'(ex_instr_ptr), 64'(m_ptr));
  endtask

  // One instruction slot: check the combinational outputs, clock, check state.
  task automatic step(input string tag);
    bit exp_jump, exp_sq;
    #1;
    exp_jump = !halt && m_sq == 0 && operation_sel == 2'd3 && m_a != 0;
    exp_sq   = !halt && m_sq != 0;
    check({tag, ".jump"},   64'(jump_taken),    64'(exp_jump));
    check({tag, ".squash"}, 64'(squash_active), 64'(exp_sq));
    check({tag, ".tgt"},    64'(jump_target),   64'({1'b0, operand_id_reg}));
    @(posedge clk);
    model_clock();
    #1;
    check_state(tag);
  endtask

  task automatic instr(input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] op,
                       input logic [2:0] opnd, input logic [4:0] wr);
    op1_sel = s1; op2_sel = s2; operation_sel = op;
    operand_id_reg = opnd; reg_wr_en = wr;
    instr_ptr_id_reg = 4'($urandom_range(0, 15));
    load_en = 1'b0;
  endtask

  task automatic load(input logic [1:0] sel, input logic [W-1:0] data);
    instr(2'd0, 2'd0, 2'd0, 3'd0, 5'd0);
    load_en = 1'b1; load_sel = sel; load_data = data;
    step("load");
  endtask

  initial begin
    rst_n = 1'b0; halt = 1'b0; load_en = 1'b0; load_sel = '0; load_data = '0;
    instr(2'd0, 2'd0, 2'd0, 3'd0, 5'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_state("reset");
    check("reset.jump",   64'(jump_taken),    64'd0);
    check("reset.squash", 64'(squash_active), 64'd0);
    #2 rst_n = 1'b1;

    // SHIFT: 729 >> 1
    load(2'd0, 48'd729);
    instr(2'd0, 2'd0, 2'd0, 3'd1, 5'b00001);
    step("shift1");
    check("shift1.val", 64'(reg_a), 64'd364);

    // XOR with literal, then with C
    load(2'd1, 48'd5);
    instr(2'd1, 2'd0, 2'd1, 3'd3, 5'b00010);
    step("xor_lit");
    check("xor_lit.val", 64'(reg_b), 64'd6);
    load(2'd2, 48'hF);
    instr(2'd1, 2'd2, 2'd1, 3'd3, 5'b00010);
    step("xor_c");
    check("xor_c.val", 64'(reg_b), 64'd9);

    // Modulo of combo A -> OUT
    load(2'd0, 48'h2F);
    instr(2'd3, 2'd0, 2'd2, 3'd4, 5'b01000);
    step("mod_out");
    check("mod_out.od", 64'(out_data), 64'd7);
    instr(2'd0, 2'd0, 2'd0, 3'd0, 5'd0);
    step("mod_out_drop");

    // Taken jump, two squashed MODs, third executes
    load(2'd0, 48'd5);
    instr(2'd0, 2'd0, 2'd3, 3'd0, 5'd0);
    #1;
    check("jnz.taken", 64'(jump_taken), 64'd1);
    step("jnz");
    for (int i = 0; i < 3; i++) begin
      instr(2'd0, 2'd0, 2'd2, 3'd0, 5'b00010);
      step("jnz_shadow");
    end
    check("jnz_shadow.b", 64'(reg_b), 64'd5);

    // Not-taken jump: A == 0
    load(2'd0, 48'd0);
    instr(2'd0, 2'd0, 2'd3, 3'd2, 5'b01111);
    step("jz");
    instr(2'd1, 2'd0, 2'd1, 3'd1, 5'b00010);
    step("jz_next");

    // SHIFT by C = 48 gives 0; operand 7 shifts by 0 and sets combo_err
    load(2'd0, 48'hFFFF);
    load(2'd2, 48'd48);
    instr(2'd0, 2'd0, 2'd0, 3'd6, 5'b00001);
    step("shift48");
    check("shift48.val", 64'(reg_a), 64'd0);
    load(2'd0, 48'h1234);
    instr(2'd2, 2'd0, 2'd0, 3'd7, 5'b00001);
    step("shift7");
    check("shift7.val", 64'(reg_a), 64'h1234);
    instr(2'd0, 2'd0, 2'd1, 3'd0, 5'd0);
    step("err_sticky");
    check("err_sticky.val", 64'(combo_err), 64'd1);

    // Halt holds A, load still lands
    load(2'd0, 48'd100);
    halt = 1'b1;
    instr(2'd0, 2'd0, 2'd0, 3'd1, 5'b01001);
    load_en = 1'b1; load_sel = 2'd1; load_data = 48'd3;
    step("halt");
    check("halt.a", 64'(reg_a), 64'd100);
    check("halt.b", 64'(reg_b), 64'd3);
    halt = 1'b0; load_en = 1'b0;
    step("unhalt");

    // Reset in the middle of a squash window
    load(2'd0, 48'd9);
    instr(2'd0, 2'd0, 2'd3, 3'd5, 5'd0);
    step("jnz2");
    instr(2'd0, 2'd0, 2'd2, 3'd0, 5'b00100);
    step("jnz2_shadow");
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check_state("mid_reset");
    check("mid_reset.squash", 64'(squash_active), 64'd0);
    check("mid_reset.jump",   64'(jump_taken),    64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized phase
    for (int n = 0; n < 400; n++) begin
      instr(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
            5'($urandom_range(0, 31)));
      halt      = ($urandom_range(0, 7) == 0);
      load_en   = ($urandom_range(0, 4) == 0);
      load_sel  = 2'($urandom_range(0, 3));
      load_data = {16'($urandom), 32'($urandom)};
      if ($urandom_range(0, 1) == 1) load_data = load_data >> $urandom_range(0, 47);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
